// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and time limits for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;
  localparam int CS_MAX = 99;
  localparam int SEC_MAX = 59;
endpackage

// File: rtl/stopwatch_ctrl_lap_reg.sv
// lap_reg: 19-bit lap time capture register with synchronous clear
module lap_reg (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [18:0] d,
  output logic [18:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear FSM with saturation guard and display mux
import stopwatch_pkg::*;

module stopwatch_ctrl #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_ss,
  input  logic       key_lc,
  input  logic [6:0] cs_in,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  output logic       pause,
  output logic       clr,
  output logic [6:0] disp_cs,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic       running,
  output logic       frozen,
  output logic       ovf
);
  state_t state;
  logic sat, sat_ev, cap;
  logic [18:0] lap;
  assign running = state == RUN || state == LAP;
  assign frozen  = state == LAP;
  assign sat     = running && cs_in == 7'(CS_MAX) && sec_in == 6'(SEC_MAX) && min_in == 6'(MAX_MIN);
  assign sat_ev  = sat && tick;
  assign cap     = state == RUN && key_lc && !key_ss && !sat_ev && !rst;
  // hold the chain at full scale so it never wraps back to zero
  assign pause   = !running || sat;
  assign {disp_min, disp_sec, disp_cs} = frozen ? lap : {min_in, sec_in, cs_in};
  lap_reg u_lap (
    .clk(clk),
    .clr(rst),
    .en (cap),
    .d  ({min_in, sec_in, cs_in}),
    .q  (lap)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ovf   <= 1'b0;
      clr   <= 1'b1;
    end else begin
      clr <= 1'b0;
      if (sat_ev) begin
        state <= STOP;
        ovf   <= 1'b1;
      end else if (key_ss) begin
        state <= running ? STOP : RUN;
      end else if (key_lc) begin
        case (state)
          IDLE: clr <= 1'b1;
          RUN:  state <= LAP;
          LAP:  state <= RUN;
          STOP: begin
            state <= IDLE;
            clr   <= 1'b1;
            ovf   <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized scoreboard bench against an integer-time stopwatch model
module tb_stopwatch_ctrl;
  localparam int MAX_MIN = 59;
  localparam int TMAX = (MAX_MIN * 60 + 59) * 100 + 99;
  typedef struct packed {
    logic        pause;
    logic        clr;
    logic        running;
    logic        frozen;
    logic        ovf;
    logic [18:0] disp;
  } exp_t;
  logic clk = 0, rst = 1, tick = 0, key_ss = 0, key_lc = 0;
  logic [6:0] cs_in = 0;
  logic [5:0] sec_in = 0, min_in = 0;
  logic pause, clr, running, frozen, ovf;
  logic [6:0] disp_cs;
  logic [5:0] disp_sec, disp_min;
  int compared = 0, mismatched = 0;
  exp_t q[$];
  bit done = 0;
  stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .rst(rst), .tick(tick), .key_ss(key_ss), .key_lc(key_lc),
    .cs_in(cs_in), .sec_in(sec_in), .min_in(min_in),
    .pause(pause), .clr(clr), .disp_cs(disp_cs), .disp_sec(disp_sec), .disp_min(disp_min),
    .running(running), .frozen(frozen), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [18:0] pack_t(int t);
    return {6'(t / 6000), 6'((t / 100) % 60), 7'(t % 100)};
  endfunction
  task automatic check(string name, logic [18:0] act, logic [18:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // model: time as a plain centisecond integer, mode as running/frozen/stopped flags
  int t = 0, lap_t = 0;
  bit m_run = 0, m_frz = 0, m_stop = 0, m_ovf = 0, m_clr = 0;
  initial begin
    exp_t e;
    bit sat, p;
    @(posedge clk);
    m_run = 0; m_frz = 0; m_stop = 0; m_ovf = 0; m_clr = 1; lap_t = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (m_run && $urandom_range(0, 39) == 0) t = TMAX - int'($urandom_range(0, 3));
      rst    = $urandom_range(0, 59) == 0;
      tick   = $urandom_range(0, 1) == 1;
      key_ss = $urandom_range(0, 6) == 0;
      key_lc = $urandom_range(0, 5) == 0;
      {min_in, sec_in, cs_in} = pack_t(t);
      sat = m_run && t == TMAX;
      p = !m_run || sat;
      #1;
      e.pause = p; e.clr = m_clr; e.running = m_run; e.frozen = m_frz; e.ovf = m_ovf;
      e.disp = m_frz ? pack_t(lap_t) : pack_t(t);
      q.push_back(e);
      @(posedge clk);
      if (rst) begin
        m_run = 0; m_frz = 0; m_stop = 0; m_ovf = 0; lap_t = 0;
      end else if (sat && tick) begin
        m_run = 0; m_frz = 0; m_stop = 1; m_ovf = 1;
      end else if (key_ss) begin
        m_stop = m_run;
        m_run = !m_run;
        m_frz = 0;
      end else if (key_lc) begin
        if (m_run && !m_frz) begin
          m_frz = 1; lap_t = t;
        end else if (m_frz) m_frz = 0;
        else begin
          if (m_stop) m_ovf = 0;
          m_stop = 0;
        end
      end
      t = m_clr ? 0 : (tick && !p ? t + 1 : t);
      m_clr = rst || (!sat || !tick) && !key_ss && key_lc && !m_run;
    end
    @(negedge clk);
    #3;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, 0 required", q.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (!done && q.size() > 0) begin
        e = q.pop_front();
        check("pause", 19'(pause), 19'(e.pause));
        check("clr", 19'(clr), 19'(e.clr));
        check("running", 19'(running), 19'(e.running));
        check("frozen", 19'(frozen), 19'(e.frozen));
        check("ovf", 19'(ovf), 19'(e.ovf));
        check("disp", {disp_min, disp_sec, disp_cs}, e.disp);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59, the highest minute value displayed before saturation.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port tick, input, 1, 100 Hz enable pulse, one clk wide.
REQ-005 SHALL have port key_ss, input, 1, debounced start/stop press, one clk wide.
REQ-006 SHALL have port key_lc, input, 1, debounced lap/clear press, one clk wide.
REQ-007 SHALL have port cs_in, input, 7, live centisecond count (0-99).
REQ-008 SHALL have port sec_in, input, 6, live second count (0-59).
REQ-009 SHALL have port min_in, input, 6, live minute count (0-MAX_MIN).
REQ-010 SHALL have port pause, output, 1, hold to the counter chain.
REQ-011 SHALL have port clr, output, 1, one-clk synchronous clear pulse to the counter chain.
REQ-012 SHALL have ports disp_cs, disp_sec and disp_min, outputs, 7/6/6 bits, time to display.
REQ-013 SHALL have ports running, frozen and ovf, outputs, 1 bit each, status flags.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, LAP and STOP.
REQ-015 IDLE transitions SHALL be: key_ss -> RUN; key_lc -> IDLE, with clr pulsed one cycle.
REQ-016 RUN transitions SHALL be: key_ss -> STOP; key_lc -> LAP, with the live time captured into the lap registers on the same edge.
REQ-017 LAP transitions SHALL be: key_lc -> RUN (display released to live); key_ss -> STOP (display released to live).
REQ-018 STOP transitions SHALL be: key_ss -> RUN; key_lc -> IDLE, with clr pulsed one cycle on the transition edge and ovf cleared.
REQ-019 When key_ss and key_lc are high in the same cycle, key_ss SHALL take priority and key_lc SHALL be ignored.
REQ-020 pause SHALL be 1 in IDLE and STOP and 0 in RUN and LAP, except as stated in REQ-021.
REQ-021 Saturation: when the state is RUN or LAP and cs_in=99, sec_in=59 and min_in=MAX_MIN, pause SHALL be asserted combinationally so the chain does not wrap; on the next edge with tick=1 the FSM SHALL enter STOP and set ovf=1.
REQ-022 A saturation event and a key press in the same cycle SHALL resolve with saturation taking priority: the FSM enters STOP and the key is ignored.
REQ-023 disp_* SHALL equal the lap registers in LAP and equal cs_in, sec_in and min_in combinationally in every other state.
REQ-024 running SHALL be 1 in RUN and LAP; frozen SHALL be 1 only in LAP.
REQ-025 clr SHALL be a registered output, high for exactly one clk per clear event.
REQ-026 Key latency SHALL be one clk: the state and registered outputs change on the edge that samples the key.
REQ-027 tick SHALL affect only saturation timing; the FSM SHALL never count ticks itself.

Reset
REQ-028 On rst=1 at a clk edge, the block SHALL enter IDLE with lap registers=0, ovf=0 and clr=1 for that one following cycle, so the counters are zeroed.
REQ-029 Reset SHALL override any simultaneous key, tick or saturation event, including mid-LAP and mid-RUN.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state encoding type plus the constants CS_MAX=99 and SEC_MAX=59.
REQ-031 The lap capture register SHALL be one sub-module, lap_reg: 19 bits, with capture enable and synchronous clear.
REQ-032 All remaining logic (FSM, saturation compare, display mux) SHALL reside in stopwatch_ctrl.

Verification
REQ-033 Reset then key_ss -> next cycle running=1, pause=0; key_ss again -> pause=1, state STOP, disp equals live count.
REQ-034 In RUN at 00:12.34, key_lc -> frozen=1, disp holds 00:12.34 while live advances; key_lc again -> frozen=0, disp live.
REQ-035 In STOP, key_lc -> clr high exactly one cycle, state IDLE, ovf=0.
REQ-036 In RUN with inputs at 59:59.99 -> pause=1 the same cycle; on the next tick -> STOP, ovf=1, count does not wrap to 00:00.00.
REQ-037 In RUN, key_ss and key_lc in the same cycle -> STOP entered, no lap capture, frozen=0.
REQ-038 Assert rst while in LAP -> next cycle IDLE, frozen=0, clr=1 for one cycle, lap registers=0.
